vga_scroll_pattern_gen: RTL and testbench

//  Parametrised scrolling test-pattern generator for the TinyVGA PMOD path.

---
 rtl/vga_scroll_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_vga_scroll_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scroll_pattern_gen.sv
// Scrolling VGA test-pattern generator: stripes/checker/gradient/solid with X/Y scroll, frame-latched controls.
// Latency: LAT clk cycles from pix_x/pix_y/video_active/hsync_in/vsync_in to r/g/b/hsync_out/vsync_out.
// Backpressure: none; free-running pixel stream, one pixel per clk.
module vga_scroll_pattern_gen #(
  parameter int          COORD_W    = 10,
  parameter int          COLOR_BITS = 2,
  parameter int          LAT        = 1,
  parameter int unsigned STEP0      = 1,
  parameter int unsigned STEP1      = 2,
  parameter int unsigned STEP2      = 6,
  parameter int unsigned STEP3      = 12,
  parameter int          CHK_SHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  input  logic                  video_active,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [1:0]            speed_sel,
  input  logic                  dir_x,
  input  logic                  y_en,
  input  logic                  pause,
  input  logic [1:0]            mode,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [7:0]            frame_cnt
);

  localparam int PW = 3 * COLOR_BITS + 2;

  localparam logic [COORD_W-1:0] STEP0_C = COORD_W'(STEP0);
  localparam logic [COORD_W-1:0] STEP1_C = COORD_W'(STEP1);
  localparam logic [COORD_W-1:0] STEP2_C = COORD_W'(STEP2);
  localparam logic [COORD_W-1:0] STEP3_C = COORD_W'(STEP3);

  // Frame-latched controls; they only change on a frame tick so a frame is never split.
  logic [1:0]         speed_q;
  logic               dir_q;
  logic               yen_q;
  logic               pause_q;
  logic [1:0]         mode_q;

  logic               vs_q;
  logic               frame_tick;
  logic [COORD_W-1:0] x_off_q, x_off_d;
  logic [COORD_W-1:0] y_off_q, y_off_d;
  logic [7:0]         frame_cnt_q;
  logic [COORD_W-1:0] step;

  logic [COORD_W-1:0] x, y;
  logic [1:0]         r_v, g_v, b_v;
  logic               chk_c;
  logic [PW-1:0]      pipe_d;
  logic [PW-1:0]      pipe_q [LAT];

  // Only a subset of the scrolled coordinate bits drives colour; fold the rest away.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x, y};

  // Rising edge of vsync, detected in the clk domain.
  assign frame_tick = vsync_in & ~vs_q;

  // Step size from the controls latched at the previous tick.
  always_comb begin
    step = STEP0_C;
    case (speed_q)
      2'd0:    step = STEP0_C;
      2'd1:    step = STEP1_C;
      2'd2:    step = STEP2_C;
      default: step = STEP3_C;
    endcase
  end

  // Next scroll offsets: modular arithmetic, no saturation.
  always_comb begin
    x_off_d = x_off_q;
    y_off_d = y_off_q;
    if (frame_tick && !pause_q) begin
      x_off_d = dir_q ? (x_off_q - step) : (x_off_q + step);
      if (yen_q) y_off_d = y_off_q + step;
    end
  end

  // Frame state: sync edge register, offsets, frame counter and control latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      x_off_q     <= '0;
      y_off_q     <= '0;
      frame_cnt_q <= '0;
      speed_q     <= '0;
      dir_q       <= 1'b0;
      yen_q       <= 1'b0;
      pause_q     <= 1'b0;
      mode_q      <= '0;
    end else begin
      vs_q    <= vsync_in;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        speed_q     <= speed_sel;
        dir_q       <= dir_x;
        yen_q       <= y_en;
        pause_q     <= pause;
        mode_q      <= mode;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;

  // Scrolled coordinates, truncated to COORD_W.
  assign x     = pix_x + x_off_q;
  assign y     = pix_y + y_off_q;
  assign chk_c = x[CHK_SHIFT] ^ y[CHK_SHIFT];

  // Repeat the 2-bit channel value MSB-first out to COLOR_BITS.
  function automatic logic [COLOR_BITS-1:0] widen(input logic [1:0] v);
    logic [COLOR_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < COLOR_BITS; i++) begin
      w[COLOR_BITS-1-i] = v[1-(i%2)];
    end
    return w;
  endfunction

  // Stage-0 colour selection from the latched mode; blanking forces black.
  always_comb begin
    r_v = 2'b00;
    g_v = 2'b00;
    b_v = 2'b00;
    if (video_active) begin
      case (mode_q)
        2'd0: begin
          r_v = {x[5], y[2]};
          g_v = {x[6], y[2]};
          b_v = {x[7], y[5]};
        end
        2'd1: begin
          r_v = {chk_c, chk_c};
          g_v = {chk_c, chk_c};
          b_v = {chk_c, chk_c};
        end
        2'd2: begin
          r_v = x[7:6];
          g_v = y[7:6];
          b_v = x[7:6] ^ y[7:6];
        end
        default: begin
          r_v = frame_cnt_q[7:6];
          g_v = frame_cnt_q[5:4];
          b_v = frame_cnt_q[3:2];
        end
      endcase
    end
  end

  assign pipe_d = {widen(r_v), widen(g_v), widen(b_v), hsync_in, vsync_in};

  // Pixel pipeline: colour and both syncs travel together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign r         = pipe_q[LAT-1][PW-1 -: COLOR_BITS];
  assign g         = pipe_q[LAT-1][PW-1-COLOR_BITS -: COLOR_BITS];
  assign b         = pipe_q[LAT-1][PW-1-2*COLOR_BITS -: COLOR_BITS];
  assign hsync_out = pipe_q[LAT-1][1];
  assign vsync_out = pipe_q[LAT-1][0];

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// Bench for vga_scroll_pattern_gen: table of per-mode pixel vectors plus directed frame sequences.
// Latency: DUT built with LAT=2; every pixel check waits LAT clocks after driving.
// Backpressure: none; all waits are fixed cycle counts.
module tb_vga_scroll_pattern_gen;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       video_active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [1:0] speed_sel = '0;
  logic       dir_x = 1'b0, y_en = 1'b0, pause = 1'b0;
  logic [1:0] mode = '0;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  vga_scroll_pattern_gen #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .speed_sel(speed_sel), .dir_x(dir_x), .y_en(y_en), .pause(pause), .mode(mode),
    .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] md;
    logic [9:0] px;
    logic [9:0] py;
    logic       act;
    logic [1:0] er;
    logic [1:0] eg;
    logic [1:0] eb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One vsync rising edge = one frame tick.
  task automatic tick();
    vsync_in = 1'b1;
    cyc();
    vsync_in = 1'b0;
    cyc();
  endtask

  task automatic pix(input int px, input int py, input logic act);
    pix_x        = 10'(px);
    pix_y        = 10'(py);
    video_active = act;
    repeat (LAT) cyc();
  endtask

  // Pins x_off/y_off mod 32 via the stripe bits x[5] (r[1]) and y[5] (b[0]); needs latched mode 0.
  task automatic chk_off(input string name, input int ex, input int ey);
    pix((32 - ex) & 1023, (32 - ey) & 1023, 1'b1);
    chk({name, "_hi"}, {30'd0, r[1], b[0]}, 32'd3);
    pix((31 - ex) & 1023, (31 - ey) & 1023, 1'b1);
    chk({name, "_lo"}, {30'd0, r[1], b[0]}, 32'd0);
  endtask

  // Asynchronous reset asserted between clock edges, outputs must clear at once.
  task automatic mid_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_r"}, r, 0);
    chk({name, "_g"}, g, 0);
    chk({name, "_b"}, b, 0);
    chk({name, "_hs"}, hsync_out, 0);
    chk({name, "_vs"}, vsync_out, 0);
    chk({name, "_fc"}, frame_cnt, 0);
    hsync_in = 1'b0; vsync_in = 1'b0; video_active = 1'b0;
    speed_sel = '0; dir_x = 1'b0; y_en = 1'b0; pause = 1'b0; mode = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    // Table phase runs with x_off=1, y_off=0 held by pause; frame_cnt = i+2 at vector i.
    tbl[0]  = '{2'd0, 10'd30,  10'd4,   1'b1, 2'b01, 2'b01, 2'b00}; // x=31,y=4
    tbl[1]  = '{2'd0, 10'd63,  10'd32,  1'b1, 2'b00, 2'b10, 2'b01}; // x=64,y=32
    tbl[2]  = '{2'd0, 10'd159, 10'd36,  1'b1, 2'b11, 2'b01, 2'b11}; // x=160,y=36
    tbl[3]  = '{2'd1, 10'd15,  10'd0,   1'b1, 2'b11, 2'b11, 2'b11}; // x4=1,y4=0
    tbl[4]  = '{2'd1, 10'd15,  10'd16,  1'b1, 2'b00, 2'b00, 2'b00}; // x4=1,y4=1
    tbl[5]  = '{2'd1, 10'd0,   10'd16,  1'b1, 2'b11, 2'b11, 2'b11}; // x4=0,y4=1
    tbl[6]  = '{2'd2, 10'd127, 10'd64,  1'b1, 2'b10, 2'b01, 2'b11}; // x=128,y=64
    tbl[7]  = '{2'd2, 10'd255, 10'd192, 1'b1, 2'b00, 2'b11, 2'b11}; // x=256,y=192
    tbl[8]  = '{2'd3, 10'd0,   10'd0,   1'b1, 2'b00, 2'b00, 2'b10}; // frame_cnt=10
    tbl[9]  = '{2'd2, 10'd127, 10'd64,  1'b0, 2'b00, 2'b00, 2'b00}; // blanked
    tbl[10] = '{2'd0, 10'd159, 10'd36,  1'b0, 2'b00, 2'b00, 2'b00}; // blanked

    // Power-on reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("por_r", r, 0);
    chk("por_g", g, 0);
    chk("por_b", b, 0);
    chk("por_hs", hsync_out, 0);
    chk("por_vs", vsync_out, 0);
    chk("por_fc", frame_cnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Freeze offsets at x_off=1,y_off=0, then sweep the vector table.
    pause = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      mode = tbl[i].md;
      tick();
      pix(tbl[i].px, tbl[i].py, tbl[i].act);
      chk($sformatf("vec%0d_r", i), r, tbl[i].er);
      chk($sformatf("vec%0d_g", i), g, tbl[i].eg);
      chk($sformatf("vec%0d_b", i), b, tbl[i].eb);
      chk($sformatf("vec%0d_fc", i), frame_cnt, i + 2);
    end

    // Mid-frame reset with live syncs and non-black pixels in flight.
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pix(159, 36, 1'b1);
    chk("pre_rst_r", r, 2'b11);
    chk("pre_rst_hs", hsync_out, 1);
    mid_reset("rst1");

    // First tick after release: frame_cnt=1, x_off 0 -> 1.
    chk_off("rst_off0", 0, 0);
    tick();
    chk("tick1_fc", frame_cnt, 1);
    chk_off("tick1_off", 1, 0);

    // Stripes after 3 frames: x_off=3, pix_x=28 -> x=31, pix_y=4.
    tick();
    tick();
    chk("str_fc", frame_cnt, 3);
    pix(28, 4, 1'b1);
    chk("str_r", r, 2'b01);
    chk("str_g", g, 2'b01);
    chk("str_b", b, 2'b00);

    // Speed change mid-frame: +1 on the next tick, +6 only from the one after.
    speed_sel = 2'd2;
    tick();
    chk_off("lat_k1", 4, 0);
    vsync_in = 1'b1;
    repeat (5) cyc();
    vsync_in = 1'b0;
    cyc();
    chk_off("lat_k2", 10, 0);
    chk("lat_fc", frame_cnt, 5);

    // Reverse wrap with Y scroll: (1,0) -> (0,1) -> (1023,2).
    mid_reset("rst2");
    dir_x = 1'b1;
    y_en  = 1'b1;
    tick();
    tick();
    chk_off("rev_0", 0, 1);
    tick();
    chk_off("rev_wrap", 1023, 2);

    // Pause: first tick still applies old controls, then offsets freeze while frame_cnt counts.
    pause = 1'b1;
    tick();
    chk_off("pause_a", 1022, 3);
    chk("pause_fc_a", frame_cnt, 4);
    repeat (4) tick();
    chk_off("pause_b", 1022, 3);
    chk("pause_fc_b", frame_cnt, 8);

    // Solid colour at frame_cnt=E4, then wrap 255 -> 0.
    mode = 2'd3;
    tick();
    repeat (219) tick();
    chk("solid_fc", frame_cnt, 8'hE4);
    pix(0, 0, 1'b1);
    chk("solid_r", r, 2'b11);
    chk("solid_g", g, 2'b10);
    chk("solid_b", b, 2'b01);
    pix(0, 0, 1'b0);
    chk("solid_blank", {r, g, b}, 0);
    repeat (28) tick();
    chk("fc_wrap", frame_cnt, 0);

    // Sync latency: single-cycle pulses come out exactly LAT=2 cycles later.
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    cyc();
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    chk("hs_n1", hsync_out, 0);
    chk("vs_n1", vsync_out, 0);
    cyc();
    chk("hs_n2", hsync_out, 1);
    chk("vs_n2", vsync_out, 1);
    cyc();
    chk("hs_n3", hsync_out, 0);
    chk("vs_n3", vsync_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
